// File: rtl/exec_unit.sv
// Execute stage of the bf8b core: LOAD, STORE and in-place ADD on data memory
// with a fixed read latency, a one-cycle done pulse and a registered zero flag.
module exec_unit #(
  parameter int                             DATA_W     = 8,
  parameter int                             ADDR_W     = 8,
  parameter int                             REG_ADDR_W = 5,
  parameter logic [ADDR_W-REG_ADDR_W-1:0]   PAGE       = '1,
  parameter int                             MEM_LAT    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [DATA_W-1:0]     val1,
  input  logic [DATA_W-1:0]     val2,
  input  logic [REG_ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic                  mem_we,
  output logic [DATA_W-1:0]     val_out,
  output logic                  zero,
  output logic                  busy,
  output logic                  done
);

  localparam int CNT_W = $clog2(MEM_LAT + 1);

  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;
  localparam logic [1:0] OP_ADD   = 2'b11;

  typedef enum logic [1:0] {IDLE, RD_WAIT, WRITE} state_t;

  state_t              state_reg, state_next;
  logic [1:0]          op_reg, op_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic [DATA_W-1:0]   val2_reg, val2_next;
  logic                nop_pend_reg, nop_pend_next;
  logic [ADDR_W-1:0]   mem_addr_reg, mem_addr_next;
  logic [DATA_W-1:0]   mem_wdata_reg, mem_wdata_next;
  logic                mem_we_reg, mem_we_next;
  logic [DATA_W-1:0]   val_reg, val_next;
  logic                zero_reg, zero_next;
  logic                done_reg, done_next;
  logic [DATA_W-1:0]   sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      op_reg        <= '0;
      cnt_reg       <= '0;
      val2_reg      <= '0;
      nop_pend_reg  <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      mem_we_reg    <= 1'b0;
      val_reg       <= '0;
      zero_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      op_reg        <= op_next;
      cnt_reg       <= cnt_next;
      val2_reg      <= val2_next;
      nop_pend_reg  <= nop_pend_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
      mem_we_reg    <= mem_we_next;
      val_reg       <= val_next;
      zero_reg      <= zero_next;
      done_reg      <= done_next;
    end
  end

  always_comb begin
    sum            = mem_rdata + val2_reg;
    state_next     = state_reg;
    op_next        = op_reg;
    cnt_next       = cnt_reg;
    val2_next      = val2_reg;
    nop_pend_next  = 1'b0;
    mem_addr_next  = mem_addr_reg;
    mem_wdata_next = mem_wdata_reg;
    mem_we_next    = 1'b0;
    val_next       = val_reg;
    zero_next      = zero_reg;
    done_next      = 1'b0;
    case (state_reg)
      IDLE: begin
        // A NOP stays in IDLE; its done is raised one edge after acceptance.
        done_next = nop_pend_reg;
        if (start) begin
          op_next       = op;
          val2_next     = val2;
          mem_addr_next = {PAGE, addr_in};
          case (op)
            OP_LOAD, OP_ADD: begin
              cnt_next   = CNT_W'(MEM_LAT - 1);
              state_next = RD_WAIT;
            end
            OP_STORE: begin
              mem_wdata_next = val1;
              mem_we_next    = 1'b1;
              state_next     = WRITE;
            end
            default: nop_pend_next = 1'b1;
          endcase
        end
      end
      RD_WAIT: begin
        if (cnt_reg != '0) begin
          cnt_next = cnt_reg - CNT_W'(1);
        end else begin
          val_next  = (op_reg == OP_ADD) ? sum : mem_rdata;
          zero_next = (val_next == '0);
          if (op_reg == OP_ADD) begin
            mem_wdata_next = sum;
            mem_we_next    = 1'b1;
            state_next     = WRITE;
          end else begin
            done_next  = 1'b1;
            state_next = IDLE;
          end
        end
      end
      WRITE: begin
        done_next  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign mem_we    = mem_we_reg;
  assign val_out   = val_reg;
  assign zero      = zero_reg;
  assign busy      = (state_reg != IDLE);
  assign done      = done_reg;

endmodule
